// File: rtl/conv_bram_sr_stride_dpath.sv
// Streaming column-window convolution datapath: un-rotate, window shift, strided fire, pipelined MAC, saturating FIFO output.
// Optional feature macro: CONV_DPATH_RELU_EN (clamp negative saturated results to zero in the saturation stage).

module conv_bram_sr_stride_dpath #(
  parameter int DATA_WIDTH     = 8,
  parameter int IMG_W          = 16,
  parameter int IMG_H          = 16,
  parameter int IMG_D          = 4,
  parameter int FILTER_L       = 3,
  parameter int STRIDE_W       = 1,
  parameter int STRIDE_H       = 1,
  parameter int PIPE_STAGES    = 2,
  parameter int OUT_FIFO_DEPTH = 4,
  parameter int OUT_SHIFT      = 0,
  localparam int RESULT_W              = (IMG_W - FILTER_L) / STRIDE_W + 1,
  localparam int RESULT_H              = (IMG_H - FILTER_L) / STRIDE_H + 1,
  localparam int N                     = FILTER_L * FILTER_L * IMG_D,
  localparam int ACC_WIDTH             = 2 * DATA_WIDTH + $clog2(N),
  localparam int RESULT_RAM_ADDR_WIDTH = (RESULT_W * RESULT_H > 1) ? $clog2(RESULT_W * RESULT_H) : 1,
  localparam int ROT_W                 = (FILTER_L > 1) ? $clog2(FILTER_L) : 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_val,
  output logic                                   in_rdy,
  input  logic [DATA_WIDTH*IMG_D*FILTER_L-1:0]   img_data_in,
  input  logic [ROT_W-1:0]                       dpath_rotation_offset,
  input  logic [DATA_WIDTH*N-1:0]                fil,
  output logic                                   result_val,
  input  logic                                   result_rdy,
  output logic [DATA_WIDTH-1:0]                  result_data_out,
  output logic [RESULT_RAM_ADDR_WIDTH-1:0]       result_wraddress,
  output logic                                   last_val
);

  // Handshakes: a beat transfers on a rising edge where in_val && in_rdy; a result
  // transfers on a rising edge where result_val && result_rdy. Neither ready depends
  // combinationally on its own valid, and result fields hold while result_val && !result_rdy.

  localparam int AW     = RESULT_RAM_ADDR_WIDTH;
  localparam int NG     = IMG_D * FILTER_L;
  localparam int PW     = 2 * DATA_WIDTH;
  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int SPH_W  = (STRIDE_W > 1) ? $clog2(STRIDE_W) : 1;
  localparam int OC_W   = (RESULT_W > 1) ? $clog2(RESULT_W) : 1;
  localparam int OR_W   = (RESULT_H > 1) ? $clog2(RESULT_H) : 1;
  localparam int PTR_W  = $clog2(OUT_FIFO_DEPTH);
  localparam int CNT_W  = $clog2(OUT_FIFO_DEPTH + 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [DATA_WIDTH-1:0] r_win     [IMG_D][FILTER_L][FILTER_L];
  logic signed [DATA_WIDTH-1:0] w_col     [IMG_D][FILTER_L];
  logic signed [DATA_WIDTH-1:0] w_win_nxt [IMG_D][FILTER_L][FILTER_L];
  logic signed [ACC_WIDTH-1:0]  w_grp     [NG];
  logic signed [PW-1:0]         w_prod;
  logic signed [ACC_WIDTH-1:0]  w_acc_final;
  logic signed [ACC_WIDTH-1:0]  w_shifted;
  logic [DATA_WIDTH-1:0]        w_sat;

  logic [COL_W-1:0] r_col_cnt;
  logic [SPH_W-1:0] r_sph;
  logic [OC_W-1:0]  r_out_col;
  logic [OR_W-1:0]  r_out_row;
  logic             w_accept;
  logic             w_fire;
  logic [AW-1:0]    w_fire_addr;
  logic             w_fire_last;

  logic             r_v [PIPE_STAGES];
  logic [AW-1:0]    r_a [PIPE_STAGES];
  logic             r_l [PIPE_STAGES];
  logic                  r_sat_v;
  logic [DATA_WIDTH-1:0] r_sat_d;
  logic [AW-1:0]         r_sat_a;
  logic                  r_sat_l;

  logic [DATA_WIDTH-1:0] r_mem_d [OUT_FIFO_DEPTH];
  logic [AW-1:0]         r_mem_a [OUT_FIFO_DEPTH];
  logic                  r_mem_l [OUT_FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_fifo_cnt;
  logic                  w_push;
  logic                  w_pop;
  int                    w_inflight;

  // BRAM rows arrive rotated: output row r lives in input slot (r + offset) mod FILTER_L.
  always_comb begin
    int src;
    src = 0;
    for (int c = 0; c < IMG_D; c++) begin
      for (int r = 0; r < FILTER_L; r++) begin
        src = r + int'(dpath_rotation_offset);
        if (src >= FILTER_L) src = src - FILTER_L;
        w_col[c][r] = img_data_in[(c*FILTER_L + src)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < IMG_D; c++) begin
      for (int r = 0; r < FILTER_L; r++) begin
        for (int k = 0; k < FILTER_L; k++) begin
          if (k == FILTER_L - 1) w_win_nxt[c][r][k] = w_col[c][r];
          else                   w_win_nxt[c][r][k] = r_win[c][r][k+1];
        end
      end
    end
  end

  // First tree level works on the post-shift window so the firing beat's own column is included.
  always_comb begin
    w_prod = '0;
    for (int c = 0; c < IMG_D; c++) begin
      for (int r = 0; r < FILTER_L; r++) begin
        w_grp[c*FILTER_L + r] = '0;
        for (int k = 0; k < FILTER_L; k++) begin
          w_prod = PW'(w_win_nxt[c][r][k]) *
                   PW'($signed(fil[((c*FILTER_L + r)*FILTER_L + k)*DATA_WIDTH +: DATA_WIDTH]));
          w_grp[c*FILTER_L + r] = w_grp[c*FILTER_L + r] + ACC_WIDTH'(w_prod);
        end
      end
    end
  end

  assign w_accept    = in_val && in_rdy;
  assign w_fire      = w_accept && (r_col_cnt >= COL_W'(FILTER_L - 1)) && (r_sph == '0);
  assign w_fire_addr = AW'(int'(r_out_col) + int'(r_out_row) * RESULT_W);
  assign w_fire_last = (w_fire_addr == AW'(RESULT_W * RESULT_H - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col_cnt <= '0;
      r_sph     <= '0;
      r_out_col <= '0;
      r_out_row <= '0;
      for (int c = 0; c < IMG_D; c++)
        for (int r = 0; r < FILTER_L; r++)
          for (int k = 0; k < FILTER_L; k++)
            r_win[c][r][k] <= '0;
    end else if (w_accept) begin
      r_win <= w_win_nxt;
      if (r_col_cnt == COL_W'(IMG_W - 1)) begin
        r_col_cnt <= '0;
        r_sph     <= '0;
      end else begin
        r_col_cnt <= r_col_cnt + COL_W'(1);
        if (r_col_cnt >= COL_W'(FILTER_L - 1))
          r_sph <= (r_sph == SPH_W'(STRIDE_W - 1)) ? '0 : r_sph + SPH_W'(1);
      end
      if (w_fire) begin
        if (r_out_col == OC_W'(RESULT_W - 1)) begin
          r_out_col <= '0;
          r_out_row <= (r_out_row == OR_W'(RESULT_H - 1)) ? '0 : r_out_row + OR_W'(1);
        end else begin
          r_out_col <= r_out_col + OC_W'(1);
        end
      end
    end
  end

  generate
    if (PIPE_STAGES == 1) begin : g_tree1
      logic signed [ACC_WIDTH-1:0] r_acc;
      logic signed [ACC_WIDTH-1:0] w_sum;
      always_comb begin
        w_sum = '0;
        for (int g = 0; g < NG; g++) w_sum = w_sum + w_grp[g];
      end
      always_ff @(posedge clk) r_acc <= w_sum;
      assign w_acc_final = r_acc;
    end else begin : g_treen
      logic signed [ACC_WIDTH-1:0] r_part [NG];
      logic signed [ACC_WIDTH-1:0] r_acc  [PIPE_STAGES-1];
      logic signed [ACC_WIDTH-1:0] w_sum;
      always_comb begin
        w_sum = '0;
        for (int g = 0; g < NG; g++) w_sum = w_sum + r_part[g];
      end
      always_ff @(posedge clk) begin
        for (int g = 0; g < NG; g++) r_part[g] <= w_grp[g];
        r_acc[0] <= w_sum;
        for (int i = 1; i < PIPE_STAGES - 1; i++) r_acc[i] <= r_acc[i-1];
      end
      assign w_acc_final = r_acc[PIPE_STAGES-2];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE_STAGES; i++) r_v[i] <= 1'b0;
      r_sat_v <= 1'b0;
    end else begin
      r_v[0] <= w_fire;
      for (int i = 1; i < PIPE_STAGES; i++) r_v[i] <= r_v[i-1];
      r_sat_v <= r_v[PIPE_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    r_a[0] <= w_fire_addr;
    r_l[0] <= w_fire_last;
    for (int i = 1; i < PIPE_STAGES; i++) begin
      r_a[i] <= r_a[i-1];
      r_l[i] <= r_l[i-1];
    end
    r_sat_d <= w_sat;
    r_sat_a <= r_a[PIPE_STAGES-1];
    r_sat_l <= r_l[PIPE_STAGES-1];
  end

  assign w_shifted = w_acc_final >>> OUT_SHIFT;

  always_comb begin
    w_sat = w_shifted[DATA_WIDTH-1:0];
    if (w_shifted > SAT_MAX)      w_sat = SAT_MAX[DATA_WIDTH-1:0];
    else if (w_shifted < SAT_MIN) w_sat = SAT_MIN[DATA_WIDTH-1:0];
`ifdef CONV_DPATH_RELU_EN
    if (w_sat[DATA_WIDTH-1]) w_sat = '0;
`endif
  end

  // Credits count every fire still in the pipe, so the FIFO can never overflow.
  always_comb begin
    w_inflight = int'(r_sat_v);
    for (int i = 0; i < PIPE_STAGES; i++) w_inflight = w_inflight + int'(r_v[i]);
  end

  assign in_rdy = !reset && ((int'(r_fifo_cnt) + w_inflight) < OUT_FIFO_DEPTH);
  assign w_push = r_sat_v;
  assign w_pop  = result_val && result_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem_d[r_wr_ptr] <= r_sat_d;
        r_mem_a[r_wr_ptr] <= r_sat_a;
        r_mem_l[r_wr_ptr] <= r_sat_l;
        r_wr_ptr <= (r_wr_ptr == PTR_W'(OUT_FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == PTR_W'(OUT_FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  assign result_val       = !reset && (r_fifo_cnt != '0);
  assign result_data_out  = result_val ? r_mem_d[r_rd_ptr] : '0;
  assign result_wraddress = result_val ? r_mem_a[r_rd_ptr] : '0;
  assign last_val         = result_val && r_mem_l[r_rd_ptr];

endmodule
